// File: rtl/gfx_transform_pkg.sv
// Shared types, matrix field layout and saturation helper for the affine point pipe.
package gfx_transform_pkg;

  localparam int unsigned DEF_POINT_W  = 16;
  localparam int unsigned DEF_SUBPIX_W = 16;
  localparam int unsigned COORD_W      = DEF_POINT_W + DEF_SUBPIX_W;
  localparam int unsigned WIDE_W       = 64;

  typedef logic signed [COORD_W-1:0]   coord_t;
  typedef logic signed [2*COORD_W-1:0] prod_t;
  typedef logic signed [WIDE_W-1:0]    wide_t;

  typedef enum logic {
    XF_FORWARD   = 1'b0,
    XF_TRANSFORM = 1'b1
  } xform_mode_e;

  // Field order inside mat_i, field 0 at the LSBs
  localparam int unsigned MAT_AA = 0;
  localparam int unsigned MAT_AB = 1;
  localparam int unsigned MAT_AC = 2;
  localparam int unsigned MAT_TX = 3;
  localparam int unsigned MAT_BA = 4;
  localparam int unsigned MAT_BB = 5;
  localparam int unsigned MAT_BC = 6;
  localparam int unsigned MAT_TY = 7;
  localparam int unsigned MAT_CA = 8;
  localparam int unsigned MAT_CB = 9;
  localparam int unsigned MAT_CC = 10;
  localparam int unsigned MAT_TZ = 11;

  // Clamp v to the signed range of a w-bit integer
  function automatic wide_t sat_coord(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/gfx_transform_row.sv
// One output row of the affine transform: products (S1), sum/round (S2), saturate (S3).
module gfx_transform_row
  import gfx_transform_pkg::*;
#(
  parameter int unsigned POINT_W  = DEF_POINT_W,
  parameter int unsigned SUBPIX_W = DEF_SUBPIX_W,
  parameter int unsigned OUT_W    = POINT_W + SUBPIX_W,
  parameter int unsigned DROP_W   = 0,
  parameter int unsigned ROUND    = 1,
  parameter int unsigned SATURATE = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                load_i,
  input  logic signed [POINT_W+SUBPIX_W-1:0]  a_i,
  input  logic signed [POINT_W+SUBPIX_W-1:0]  b_i,
  input  logic signed [POINT_W+SUBPIX_W-1:0]  c_i,
  input  logic signed [POINT_W+SUBPIX_W-1:0]  t_i,
  input  logic signed [POINT_W+SUBPIX_W-1:0]  x_i,
  input  logic signed [POINT_W+SUBPIX_W-1:0]  y_i,
  input  logic signed [POINT_W+SUBPIX_W-1:0]  z_i,
  output logic signed [OUT_W-1:0]             res_o,
  output logic                                ovf_o
);

  localparam int unsigned CW = POINT_W + SUBPIX_W;
  localparam int unsigned PW = 2 * CW;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned RW = SW - SUBPIX_W - DROP_W;
  localparam logic signed [SW-1:0] RND_ADD =
    (ROUND != 0) ? (SW'(1) <<< (SUBPIX_W - 1)) : SW'(0);

  logic signed [PW-1:0]     p0_q, p1_q, p2_q;
  logic signed [CW-1:0]     t_q;
  logic signed [RW-1:0]     rnd_q;
  logic signed [SW-1:0]     sum_c;
  wide_t                    wide_c;
  logic signed [OUT_W-1:0]  trunc_c;
  logic signed [OUT_W-1:0]  res_c;
  logic                     ovf_c;

  // Translation is aligned to the product fraction; floor comes from the arithmetic shift
  always_comb begin
    sum_c   = SW'(p0_q) + SW'(p1_q) + SW'(p2_q) + (SW'(t_q) <<< SUBPIX_W) + RND_ADD;
    wide_c  = WIDE_W'(rnd_q);
    trunc_c = wide_c[OUT_W-1:0];
    ovf_c   = (wide_c != WIDE_W'(trunc_c));
    res_c   = (SATURATE != 0) ? OUT_W'(sat_coord(wide_c, OUT_W)) : trunc_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      t_q   <= '0;
      rnd_q <= '0;
      res_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (load_i) begin
        p0_q <= PW'(a_i) * PW'(x_i);
        p1_q <= PW'(b_i) * PW'(y_i);
        p2_q <= PW'(c_i) * PW'(z_i);
        t_q  <= t_i;
      end
      rnd_q <= RW'(sum_c >>> (SUBPIX_W + DROP_W));
      res_o <= res_c;
      ovf_o <= ovf_c;
    end
  end

endmodule

// File: rtl/gfx_transform_pipe.sv
// Three-stage affine point transformer writing results into NUM_SLOTS vertex slots.
module gfx_transform_pipe
  import gfx_transform_pkg::*;
#(
  parameter int unsigned POINT_W   = DEF_POINT_W,
  parameter int unsigned SUBPIX_W  = DEF_SUBPIX_W,
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned ID_W      = $clog2(NUM_SLOTS),
  parameter int unsigned ROUND     = 1,
  parameter int unsigned SATURATE  = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic                                    mode_i,
  input  logic [ID_W-1:0]                         id_i,
  input  logic [POINT_W+SUBPIX_W-1:0]             x_i,
  input  logic [POINT_W+SUBPIX_W-1:0]             y_i,
  input  logic [POINT_W+SUBPIX_W-1:0]             z_i,
  input  logic [12*(POINT_W+SUBPIX_W)-1:0]        mat_i,
  input  logic                                    clear_i,
  output logic [NUM_SLOTS*(POINT_W+SUBPIX_W)-1:0] px_o,
  output logic [NUM_SLOTS*(POINT_W+SUBPIX_W)-1:0] py_o,
  output logic [NUM_SLOTS*POINT_W-1:0]            pz_o,
  output logic                                    ack_o,
  output logic [ID_W-1:0]                         ack_id_o,
  output logic                                    ovf_o,
  output logic                                    id_err_o
);

  localparam int unsigned CW = POINT_W + SUBPIX_W;

  logic                 accept_c;
  logic [CW-1:0]        res_x, res_y;
  logic [POINT_W-1:0]   res_z;
  logic                 ovf_x, ovf_y, ovf_z;

  logic                 v_q    [3];
  xform_mode_e          mode_q [3];
  logic [ID_W-1:0]      id_q   [3];
  logic [CW-1:0]        fx_q   [3];
  logic [CW-1:0]        fy_q   [3];
  logic [POINT_W-1:0]   fz_q   [3];

  assign in_ready_o = rst_ni & ~clear_i;
  assign accept_c   = in_valid_i & in_ready_o;

  gfx_transform_row #(
    .POINT_W(POINT_W), .SUBPIX_W(SUBPIX_W), .OUT_W(CW), .DROP_W(0),
    .ROUND(ROUND), .SATURATE(SATURATE)
  ) u_row_x (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(accept_c),
    .a_i(mat_i[MAT_AA*CW +: CW]), .b_i(mat_i[MAT_AB*CW +: CW]),
    .c_i(mat_i[MAT_AC*CW +: CW]), .t_i(mat_i[MAT_TX*CW +: CW]),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .res_o(res_x), .ovf_o(ovf_x)
  );

  gfx_transform_row #(
    .POINT_W(POINT_W), .SUBPIX_W(SUBPIX_W), .OUT_W(CW), .DROP_W(0),
    .ROUND(ROUND), .SATURATE(SATURATE)
  ) u_row_y (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(accept_c),
    .a_i(mat_i[MAT_BA*CW +: CW]), .b_i(mat_i[MAT_BB*CW +: CW]),
    .c_i(mat_i[MAT_BC*CW +: CW]), .t_i(mat_i[MAT_TY*CW +: CW]),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .res_o(res_y), .ovf_o(ovf_y)
  );

  // z keeps only the floored integer part of its result
  gfx_transform_row #(
    .POINT_W(POINT_W), .SUBPIX_W(SUBPIX_W), .OUT_W(POINT_W), .DROP_W(SUBPIX_W),
    .ROUND(ROUND), .SATURATE(SATURATE)
  ) u_row_z (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(accept_c),
    .a_i(mat_i[MAT_CA*CW +: CW]), .b_i(mat_i[MAT_CB*CW +: CW]),
    .c_i(mat_i[MAT_CC*CW +: CW]), .t_i(mat_i[MAT_TZ*CW +: CW]),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .res_o(res_z), .ovf_o(ovf_z)
  );

  // Control and forward-path sidebands travel alongside the row datapaths
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 3; i++) begin
        v_q[i]    <= 1'b0;
        mode_q[i] <= XF_FORWARD;
        id_q[i]   <= '0;
        fx_q[i]   <= '0;
        fy_q[i]   <= '0;
        fz_q[i]   <= '0;
      end
    end else begin
      v_q[0] <= accept_c;
      if (accept_c) begin
        mode_q[0] <= xform_mode_e'(mode_i);
        id_q[0]   <= id_i;
        fx_q[0]   <= x_i;
        fy_q[0]   <= y_i;
        fz_q[0]   <= z_i[CW-1:SUBPIX_W];
      end
      for (int unsigned i = 1; i < 3; i++) begin
        v_q[i]    <= v_q[i-1] & ~clear_i;
        mode_q[i] <= mode_q[i-1];
        id_q[i]   <= id_q[i-1];
        fx_q[i]   <= fx_q[i-1];
        fy_q[i]   <= fy_q[i-1];
        fz_q[i]   <= fz_q[i-1];
      end
    end
  end

  // Writeback into the slots; clear wins over a retiring point
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      px_o     <= '0;
      py_o     <= '0;
      pz_o     <= '0;
      ack_o    <= 1'b0;
      ack_id_o <= '0;
      ovf_o    <= 1'b0;
      id_err_o <= 1'b0;
    end else if (clear_i) begin
      px_o     <= '0;
      py_o     <= '0;
      pz_o     <= '0;
      ack_o    <= 1'b0;
      ovf_o    <= 1'b0;
      id_err_o <= 1'b0;
    end else begin
      ack_o <= v_q[2];
      if (v_q[2]) begin
        ack_id_o <= id_q[2];
        if (32'(id_q[2]) >= NUM_SLOTS) id_err_o <= 1'b1;
        if (mode_q[2] == XF_TRANSFORM) ovf_o <= ovf_o | ovf_x | ovf_y | ovf_z;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
          if (32'(id_q[2]) == s) begin
            px_o[s*CW +: CW]           <= (mode_q[2] == XF_TRANSFORM) ? res_x : fx_q[2];
            py_o[s*CW +: CW]           <= (mode_q[2] == XF_TRANSFORM) ? res_y : fy_q[2];
            pz_o[s*POINT_W +: POINT_W] <= (mode_q[2] == XF_TRANSFORM) ? res_z : fz_q[2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gfx_transform_pipe.sv
// Directed bench for gfx_transform_pipe with hand-computed slot and flag expectations.
module tb_gfx_transform_pipe;
  import gfx_transform_pkg::*;

  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mode = 1'b0;
  logic [1:0]    id = '0;
  logic [31:0]   x = '0, y = '0, z = '0;
  logic [383:0]  mat = '0;
  logic          clear = 1'b0;
  logic [95:0]   px, py;
  logic [47:0]   pz;
  logic          ack;
  logic [1:0]    ack_id;
  logic          ovf, id_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] ex [3];
  logic [31:0] ey [3];
  logic [15:0] ez [3];

  gfx_transform_pipe #(
    .POINT_W(16), .SUBPIX_W(16), .NUM_SLOTS(3), .ROUND(1), .SATURATE(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .id_i(id), .x_i(x), .y_i(y), .z_i(z), .mat_i(mat),
    .clear_i(clear), .px_o(px), .py_o(py), .pz_o(pz), .ack_o(ack),
    .ack_id_o(ack_id), .ovf_o(ovf), .id_err_o(id_err)
  );

  always #5 clk = ~clk;

  function automatic logic [383:0] mk_mat(input logic [31:0] aa, bb, cc, tx);
    logic [383:0] m;
    m = '0;
    m[MAT_AA*CW +: CW] = aa;
    m[MAT_BB*CW +: CW] = bb;
    m[MAT_CC*CW +: CW] = cc;
    m[MAT_TX*CW +: CW] = tx;
    return m;
  endfunction

  // Present one point for exactly one accept edge; returns at the following negedge
  task automatic drive(input logic m, input logic [1:0] i, input logic [31:0] xv, yv, zv);
    in_valid = 1'b1; mode = m; id = i; x = xv; y = yv; z = zv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", in_ready); end
    checks++; if ({ack, ack_id, ovf, id_err} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {ack, ack_id, ovf, id_err}); end
    checks++; if ({px, py, pz} !== '0) begin errors++; $display("FAIL rst_slots got %h exp 0", {px, py, pz}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %0b exp 1", in_ready); end
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin ex[s] = '0; ey[s] = '0; ez[s] = '0; end
  endtask

  task automatic test_identity();
    mat = mk_mat(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
    drive(1'b1, 2'd0, 32'h0001_8000, 32'hFFFF_0000, 32'h0003_C000);
    mat = '1;
    @(negedge clk); @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL id_early_ack got %0b exp 0", ack); end
    @(negedge clk);
    checks++; if (ack !== 1'b1 || ack_id !== 2'd0) begin errors++; $display("FAIL id_ack got %0b/%0d exp 1/0", ack, ack_id); end
    ex[0] = 32'h0001_8000; ey[0] = 32'hFFFF_0000; ez[0] = 16'h0003;
    checks++; if ({px[0 +: 32], py[0 +: 32], pz[0 +: 16]} !== {ex[0], ey[0], ez[0]})
      begin errors++; $display("FAIL id_slot0 got %h %h %h exp %h %h %h", px[0 +: 32], py[0 +: 32], pz[0 +: 16], ex[0], ey[0], ez[0]); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL id_ovf got %0b exp 0", ovf); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL id_pulse got %0b exp 0", ack); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xin [3];
    logic [31:0] xexp [3];
    xin[0] = 32'h0001_0000; xin[1] = 32'h0002_4000; xin[2] = 32'hFFFE_0000;
    xexp[0] = 32'h0001_8000; xexp[1] = 32'h0002_C000; xexp[2] = 32'hFFFE_8000;
    mat = mk_mat(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000);
    for (int k = 0; k < 3; k++) drive(1'b1, 2'(k), xin[k], 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ack !== 1'b1 || ack_id !== 2'(k)) begin errors++; $display("FAIL b2b_ack%0d got %0b/%0d exp 1/%0d", k, ack, ack_id, k); end
    end
    for (int s = 0; s < 3; s++) begin
      ex[s] = xexp[s]; ey[s] = '0; ez[s] = '0;
      checks++; if ({px[s*32 +: 32], py[s*32 +: 32], pz[s*16 +: 16]} !== {ex[s], ey[s], ez[s]})
        begin errors++; $display("FAIL b2b_slot%0d got %h %h %h exp %h %h %h", s, px[s*32 +: 32], py[s*32 +: 32], pz[s*16 +: 16], ex[s], ey[s], ez[s]); end
    end
  endtask

  task automatic test_forward();
    mat = mk_mat(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0000_8000);
    drive(1'b0, 2'd2, 32'h7FFF_0000, 32'h8765_4321, 32'hFFFF_8000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (ack !== 1'b1 || ack_id !== 2'd2) begin errors++; $display("FAIL fwd_ack got %0b/%0d exp 1/2", ack, ack_id); end
    ex[2] = 32'h7FFF_0000; ey[2] = 32'h8765_4321; ez[2] = 16'hFFFF;
    for (int s = 0; s < 3; s++) begin
      checks++; if ({px[s*32 +: 32], py[s*32 +: 32], pz[s*16 +: 16]} !== {ex[s], ey[s], ez[s]})
        begin errors++; $display("FAIL fwd_slot%0d got %h %h %h exp %h %h %h", s, px[s*32 +: 32], py[s*32 +: 32], pz[s*16 +: 16], ex[s], ey[s], ez[s]); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fwd_ovf got %0b exp 0", ovf); end
  endtask

  task automatic test_saturate_round();
    mat = mk_mat(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
    drive(1'b1, 2'd1, 32'h4000_0000, 32'h0002_0000, 32'hFFFF_C000);
    @(negedge clk); @(negedge clk);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_early got %0b exp 0", ovf); end
    @(negedge clk);
    ex[1] = 32'h7FFF_FFFF; ey[1] = 32'h0002_0000; ez[1] = 16'hFFFF;
    checks++; if ({px[32 +: 32], py[32 +: 32], pz[16 +: 16]} !== {ex[1], ey[1], ez[1]})
      begin errors++; $display("FAIL sat_slot1 got %h %h %h exp %h %h %h", px[32 +: 32], py[32 +: 32], pz[16 +: 16], ex[1], ey[1], ez[1]); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %0b exp 1", ovf); end
    // half-LSB products: +0.5 LSB rounds up to 1, -0.5 LSB rounds up to 0
    mat = mk_mat(32'h0000_8000, 32'h0000_8000, 32'h0001_0000, 32'h0);
    drive(1'b1, 2'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0005_0000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    ex[0] = 32'h0000_0001; ey[0] = 32'h0000_0000; ez[0] = 16'h0005;
    checks++; if ({px[0 +: 32], py[0 +: 32], pz[0 +: 16]} !== {ex[0], ey[0], ez[0]})
      begin errors++; $display("FAIL rnd_slot0 got %h %h %h exp %h %h %h", px[0 +: 32], py[0 +: 32], pz[0 +: 16], ex[0], ey[0], ez[0]); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_sticky got %0b exp 1", ovf); end
  endtask

  task automatic test_id_err();
    drive(1'b0, 2'd3, 32'h1234_0000, 32'h5678_0000, 32'h0009_0000);
    @(negedge clk); @(negedge clk);
    checks++; if (id_err !== 1'b0) begin errors++; $display("FAIL iderr_early got %0b exp 0", id_err); end
    @(negedge clk);
    checks++; if (ack !== 1'b1 || ack_id !== 2'd3) begin errors++; $display("FAIL iderr_ack got %0b/%0d exp 1/3", ack, ack_id); end
    checks++; if (id_err !== 1'b1) begin errors++; $display("FAIL iderr_flag got %0b exp 1", id_err); end
    for (int s = 0; s < 3; s++) begin
      checks++; if ({px[s*32 +: 32], py[s*32 +: 32], pz[s*16 +: 16]} !== {ex[s], ey[s], ez[s]})
        begin errors++; $display("FAIL iderr_slot%0d got %h %h %h exp %h %h %h", s, px[s*32 +: 32], py[s*32 +: 32], pz[s*16 +: 16], ex[s], ey[s], ez[s]); end
    end
  endtask

  task automatic test_clear();
    drive(1'b0, 2'd0, 32'hAAAA_0000, 32'h5555_0000, 32'h0007_0000);
    @(negedge clk); @(negedge clk);
    clear = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %0b exp 0", in_ready); end
    @(negedge clk);
    clear = 1'b0;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL clr_discard_ack got %0b exp 0", ack); end
    checks++; if ({px, py, pz} !== '0) begin errors++; $display("FAIL clr_slots got %h exp 0", {px, py, pz}); end
    checks++; if ({ovf, id_err} !== 2'b00) begin errors++; $display("FAIL clr_flags got %b exp 00", {ovf, id_err}); end
    for (int s = 0; s < 3; s++) begin ex[s] = '0; ey[s] = '0; ez[s] = '0; end
    @(negedge clk);
    checks++; if (ack !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clr_after got %0b/%0b exp 0/1", ack, in_ready); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 2'd1, 32'h1111_0000, 32'h2222_0000, 32'h0002_0000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (px[32 +: 32] !== 32'h1111_0000) begin errors++; $display("FAIL rmid_pre got %h exp 11110000", px[32 +: 32]); end
    drive(1'b0, 2'd2, 32'h3333_0000, 32'h4444_0000, 32'h0004_0000);
    rst_n = 1'b0;
    #1;
    checks++; if ({px, py, pz} !== '0) begin errors++; $display("FAIL rmid_slots got %h exp 0", {px, py, pz}); end
    checks++; if ({in_ready, ack, ack_id, ovf, id_err} !== 6'b0) begin errors++; $display("FAIL rmid_outs got %b exp 000000", {in_ready, ack, ack_id, ovf, id_err}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rmid_ack%0d got %0b exp 0", c, ack); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_forward();
    test_saturate_round();
    test_id_err();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfx_transform_pipe.md
Name: gfx_transform_pipe

Overview:
- Pipelined, parametrised 4x3 affine point transformer for the GFX accelerator, sitting between the command decoder and the rasteriser setup.
- Accepts one point per cycle via a valid/ready handshake.
- Either transforms the point (X' = M·X + T) or forwards it unchanged, then writes the result into one of NUM_SLOTS vertex slots.
- Adds over the previous generation: full throughput, optional rounding and saturation, an overflow flag, slot clear and out-of-range id detection.

Parameters:
- POINT_W, 16, integer bits of each coordinate (two's complement).
- SUBPIX_W, 16, fractional bits of each coordinate.
- NUM_SLOTS, 3, number of vertex slots (2..16).
- ID_W, $clog2(NUM_SLOTS), width of point id.
- ROUND, 1, 1 = round half up at the product LSB, 0 = truncate.
- SATURATE, 1, 1 = clamp results to range, 0 = wrap.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  point presented.
- in_ready_o  out  1  point accepted when valid & ready.
- mode_i  in  1  0 = forward, 1 = transform.
- id_i  in  ID_W  destination slot.
- x_i, y_i, z_i  in  POINT_W+SUBPIX_W each  signed input point.
- mat_i  in  12*(POINT_W+SUBPIX_W)  packed aa,ab,ac,tx,ba,bb,bc,ty,ca,cb,cc,tz; aa at LSBs.
- clear_i  in  1  synchronous clear of all slots and flags.
- px_o, py_o  out  NUM_SLOTS*(POINT_W+SUBPIX_W)  slot x/y; slot 0 at LSBs.
- pz_o  out  NUM_SLOTS*POINT_W  slot z, integer part.
- ack_o  out  1  one-cycle pulse per retired point.
- ack_id_o  out  ID_W  id of the retired point.
- ovf_o  out  1  sticky: any transform result saturated or wrapped.
- id_err_o  out  1  sticky: a point was accepted with id >= NUM_SLOTS.

Behaviour:
- Reset (rst_ni low, asynchronous): all slots 0, ack_o=0, ack_id_o=0, ovf_o=0, id_err_o=0, pipeline valid bits 0. in_ready_o=0 while in reset; otherwise 1.
- in_ready_o = !clear_i. No other backpressure; throughput is one point per cycle.

Pipeline (a valid bit travels with every stage):
- S1, accept cycle: register the 9 products (2*(POINT_W+SUBPIX_W) bits, 2*SUBPIX_W fraction bits), translations, raw x/y/z, mode and id. The matrix is sampled only at accept, so later mat_i changes do not affect in-flight points.
- S2: per row, sum = p0+p1+p2+(t << SUBPIX_W), with 2 guard bits. If ROUND, add 2^(SUBPIX_W-1) before dropping SUBPIX_W LSBs.
- S3, writeback:
  - Transform: x/y are the sum clamped to [-2^(POINT_W-1), 2^(POINT_W-1)-2^-SUBPIX_W] when SATURATE=1, or low bits otherwise.
  - Transform z: floor of the result, clamped to the POINT_W signed range when SATURATE=1.
  - Forward: x/y copied; z takes the integer bits z_i[POINT_W+SUBPIX_W-1:SUBPIX_W], with no rounding.
  - Write slot id; pulse ack_o; ack_id_o = id.
- Latency: ack_o and slot update occur exactly 3 cycles after the accept edge (accept at edge n, visible after edge n+3). Forward points use the same latency, so ordering is preserved.

Flags and boundary cases:
- ovf_o sets in S3 if any of x/y/z of a transform exceeded range, whether clamped or wrapped. It never sets for forward.
- id >= NUM_SLOTS: no slot written; ack_o still pulses; id_err_o sets.
- Two in-flight points with the same id: the later one overwrites, in order.
- clear_i: zeros all slots, ovf_o and id_err_o, and pipeline valid bits at the next edge. Any S3 writeback in the same cycle is discarded and does not ack.
- Reset mid-operation: in-flight points are lost and no ack is issued.

Decomposition:
- Package gfx_transform_pkg holds:
  - typedef coord_t (signed POINT_W+SUBPIX_W);
  - typedef prod_t;
  - enum xform_mode_e {XF_FORWARD, XF_TRANSFORM};
  - localparams for matrix field indices (MAT_AA..MAT_TZ);
  - function sat_coord.
- One sub-module, gfx_transform_row: computes one row's 3 products, sum, round and saturate, with an ovf output. It is instantiated 3 times.

Test Plan:
- Identity matrix (aa=bb=cc=0x0001_0000, rest 0); transform x=0x0001_8000, y=0xFFFF_0000, z=0x0003_C000, id=0 -> 3 cycles later ack_o=1, ack_id_o=0, slot0 x=0x0001_8000, y=0xFFFF_0000, z=3.
- aa=0x0002_0000 (2.0), x=0x4000_0000, SATURATE=1 -> slot x=0x7FFF_FFFF, ovf_o=1 sticky until clear_i.
- Three back-to-back transforms, ids 0,1,2, on consecutive cycles with tx=0x0000_8000 -> acks on 3 consecutive cycles with ack_id_o 0,1,2; each slot x = input x + 0.5.
- Forward z=0xFFFF_8000 (-0.5), mode 0 -> pz slot = 0xFFFF (floor -1); ovf_o stays 0.
- id=3 with NUM_SLOTS=3 -> ack_o pulses, no slot changes, id_err_o=1. Then clear_i for 1 cycle -> all slots 0, flags 0, in_ready_o=0 that cycle.
- Assert rst_ni low one cycle after accepting a point -> no ack_o ever appears for that point; all outputs 0 immediately, without waiting for a clock edge.
